demux1ton_stream: RTL and testbench
===================================

DEMUX1TON_STREAM -- requirements
Module: demux1ton_stream

Interface
REQ-001 Parameter WIDTH, default 8: data bits per transfer.
REQ-002 Parameter N, default 4: output channel count, legal range 2..16.
REQ-003 Parameter SELW, default 2: select width, SHALL equal clog2(N).
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 din  input  WIDTH  input data.
REQ-007 sel  input  SELW  destination channel, qualified by din_valid.
REQ-008 din_valid  input  1  input transfer offered.
REQ-009 din_ready  output  1  input transfer accepted when din_valid and din_ready are both high.
REQ-010 dout  output  N*WIDTH  flat bus; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-011 dout_valid  output  N  per-channel valid, at most one bit high (one-hot or zero).
REQ-012 dout_ready  input  N  per-channel downstream ready.
REQ-013 err_oor  output  1  sticky flag: a transfer with sel >= N was accepted.

Function
REQ-014 Single-entry output register holding {data, dest}; two states: EMPTY, FULL.
- EMPTY -> FULL on input accept.
- FULL -> EMPTY when dout_valid[dest] & dout_ready[dest] and no new accept.
- FULL -> FULL on a simultaneous drain and accept (pass-through).
REQ-015 Latency: data accepted in cycle t appears on dout/dout_valid in cycle t+1.
REQ-016 din_ready = EMPTY | dout_ready[dest]; it SHALL NOT depend on din_valid or sel.
REQ-017 In FULL, dout_valid[dest]=1 and all other bits are 0; dout for every channel carries the held data.
REQ-018 Held data and dest SHALL remain stable while dout_ready[dest]=0.
REQ-019 A transfer with sel >= N:
- is accepted when din_ready=1;
- is not registered (state unchanged, or drains normally);
- sets err_oor.
REQ-020 Head-of-line blocking is intended: a stalled channel blocks all channels.
REQ-021 dout_ready bits of non-destination channels are ignored.

Reset
REQ-022 On a clk edge with rst_n=0:
- state = EMPTY;
- dout_valid = 0;
- dout = 0;
- err_oor = 0;
- drop counter (if present) = 0.
REQ-023 Reset asserted while FULL discards the held entry; no output transfer completes in that cycle.
REQ-024 While rst_n=0, din_ready SHALL be 0.

Configuration
REQ-025 Macro DEMUX1TON_DROP_CNT_EN.
- Defined: adds output drop_cnt [15:0], counting accepted transfers with sel >= N; saturates at 16'hFFFF; cleared by reset.
- Undefined: the port and its logic are absent, and err_oor behaviour is unchanged.

Structure
REQ-026 Package demux_pkg holds:
- the state enum type (EMPTY, FULL);
- the localparam DROP_CNT_MAX = 16'hFFFF;
- a clog2-based helper used to check SELW.
REQ-027 The sub-module demux_slot implements the one-entry {data, dest} register with load/drain controls; demux1ton_stream instantiates it once.
REQ-028 An elaboration-time check SHALL fail if SELW != clog2(N) or N is outside 2..16.

Verification
REQ-029 Reset: rst_n=0 for 2 cycles with din_valid=1 -> din_ready=0, dout_valid=0, err_oor=0.
REQ-030 Basic route (WIDTH=8, N=4): din=8'hA5, sel=2, all dout_ready=1 -> next cycle dout_valid=4'b0100, dout[23:16]=8'hA5.
REQ-031 Stall: dout_ready[1]=0, send 8'h11 to ch1 then 8'h22 to ch3 -> 8'h11 is held stable and din_ready=0; after ready[1]=1 for one cycle, 8'h22 appears on ch3 the next cycle.
REQ-032 Back-to-back: 4 transfers to ch0..3 on consecutive cycles with all ready -> one transfer per cycle, no bubbles, correct dout_valid order 0001, 0010, 0100, 1000.
REQ-033 Out-of-range (N=3, SELW=2): sel=3, din=8'hFF -> no dout_valid, err_oor=1 and held until reset; with DEMUX1TON_DROP_CNT_EN, drop_cnt=1.
REQ-034 Mid-operation reset: rst_n=0 while FULL with ready=0 -> next cycle state EMPTY, dout_valid=0, and the entry is never delivered.

Source files
------------

// File: rtl/demux_pkg.sv
// demux_pkg
//   Shared types and helpers for the 1-to-N stream demultiplexer.
//   - demux_state_e : occupancy of the single output slot (EMPTY / FULL)
//   - DROP_CNT_MAX  : saturation value of the optional drop counter
//   - demux_clog2() : ceil(log2(value)), used to check the select width
package demux_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } demux_state_e;

    localparam logic [15:0] DROP_CNT_MAX = 16'hFFFF;

    // Smallest r with 2**r >= value (value >= 1).
    function automatic int demux_clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot
//   One-entry {data, dest} holding register with load/drain controls.
//   Load has priority over drain so a simultaneous drain+load passes the
//   new entry straight through without a bubble.
// Ports
//   clk      : clock, rising edge
//   rst_n    : synchronous active-low reset (empties slot, clears data/dest)
//   i_load   : write i_data/i_dest into the slot, slot becomes FULL
//   i_drain  : current entry consumed downstream
//   i_data   : data to store
//   i_dest   : destination channel to store
//   o_full   : slot holds a valid entry
//   o_data   : held data
//   o_dest   : held destination channel
module demux_slot #(
    parameter int WIDTH = 8,
    parameter int SELW  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_load,
    input  logic             i_drain,
    input  logic [WIDTH-1:0] i_data,
    input  logic [SELW-1:0]  i_dest,
    output logic             o_full,
    output logic [WIDTH-1:0] o_data,
    output logic [SELW-1:0]  o_dest
);
    import demux_pkg::*;

    demux_state_e     r_state;
    demux_state_e     w_state_next;
    logic [WIDTH-1:0] r_data;
    logic [SELW-1:0]  r_dest;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            EMPTY: begin
                if (i_load) begin
                    w_state_next = FULL;
                end
            end
            FULL: begin
                if (i_load) begin
                    w_state_next = FULL;
                end else if (i_drain) begin
                    w_state_next = EMPTY;
                end
            end
            default: w_state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_data  <= '0;
            r_dest  <= '0;
        end else begin
            r_state <= w_state_next;
            // Data/dest only change on load, so they stay stable while stalled.
            if (i_load) begin
                r_data <= i_data;
                r_dest <= i_dest;
            end
        end
    end

    assign o_full = (r_state == FULL);
    assign o_data = r_data;
    assign o_dest = r_dest;

endmodule

// File: rtl/demux1ton_stream.sv
// demux1ton_stream
//   Valid/ready 1-to-N stream demultiplexer with a single-entry output
//   register. One cycle latency; a stalled destination blocks every channel
//   (head-of-line blocking). Transfers addressed to sel >= N are accepted,
//   discarded and flagged on the sticky err_oor output.
// Optional feature
//   DEMUX1TON_DROP_CNT_EN : adds drop_cnt[15:0], a saturating count of
//                           accepted out-of-range transfers.
// Ports
//   clk         : clock, rising edge
//   rst_n       : synchronous active-low reset
//   din         : input data
//   sel         : destination channel, qualified by din_valid
//   din_valid   : input transfer offered
//   din_ready   : input transfer accepted when din_valid & din_ready
//   dout        : flat bus, channel k at [k*WIDTH +: WIDTH]; all carry held data
//   dout_valid  : per-channel valid, one-hot or zero
//   dout_ready  : per-channel downstream ready
//   err_oor     : sticky, an out-of-range transfer was accepted
//   drop_cnt    : (optional) saturating out-of-range transfer count
module demux1ton_stream #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SELW  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [WIDTH-1:0]   din,
    input  logic [SELW-1:0]    sel,
    input  logic               din_valid,
    output logic               din_ready,
    output logic [N*WIDTH-1:0] dout,
    output logic [N-1:0]       dout_valid,
    input  logic [N-1:0]       dout_ready,
    output logic               err_oor
`ifdef DEMUX1TON_DROP_CNT_EN
    ,
    output logic [15:0]        drop_cnt
`endif
);
    import demux_pkg::*;

    generate
        if (SELW != demux_clog2(N) || N < 2 || N > 16) begin : g_param_check
            $fatal(1, "demux1ton_stream: illegal N=%0d / SELW=%0d", N, SELW);
        end
    endgenerate

    logic [N-1:0]     w_sel_dec;
    logic             w_in_range;
    logic             w_accept;
    logic             w_load;
    logic             w_drop;
    logic             w_drain;
    logic             w_slot_full;
    logic [WIDTH-1:0] w_slot_data;
    logic [SELW-1:0]  w_slot_dest;
    logic             r_err_oor;

    // Decode sel against the real channel count; no hit means out of range.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_sel_dec
            assign w_sel_dec[gi] = (sel == SELW'(gi));
        end
    endgenerate
    assign w_in_range = |w_sel_dec;

    // Valid is gated by rst_n so an entry caught by reset is never handed off.
    generate
        for (gi = 0; gi < N; gi++) begin : g_out
            assign dout_valid[gi]              = rst_n & w_slot_full & (w_slot_dest == SELW'(gi));
            assign dout[gi*WIDTH +: WIDTH]     = w_slot_data;
        end
    endgenerate

    // Only the destination bit of dout_valid can be set, so this picks
    // dout_ready[dest] and ignores every other ready bit.
    assign w_drain   = |(dout_valid & dout_ready);
    assign din_ready = rst_n & (~w_slot_full | w_drain);
    assign w_accept  = din_valid & din_ready;
    assign w_load    = w_accept & w_in_range;
    assign w_drop    = w_accept & ~w_in_range;

    demux_slot #(
        .WIDTH (WIDTH),
        .SELW  (SELW)
    ) u_slot (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_drain (w_drain),
        .i_data  (din),
        .i_dest  (sel),
        .o_full  (w_slot_full),
        .o_data  (w_slot_data),
        .o_dest  (w_slot_dest)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_err_oor <= 1'b0;
        end else if (w_drop) begin
            r_err_oor <= 1'b1;
        end
    end
    assign err_oor = r_err_oor;

`ifdef DEMUX1TON_DROP_CNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_drop_cnt <= '0;
        end else if (w_drop && (r_drop_cnt != DROP_CNT_MAX)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
        end
    end
    assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_demux1ton_stream.sv
module tb_demux1ton_stream;

    logic        clk;
    // Main DUT: WIDTH=8, N=4
    logic        rst_n;
    logic [7:0]  din;
    logic [1:0]  sel;
    logic        din_valid;
    logic        din_ready;
    logic [31:0] dout;
    logic [3:0]  dout_valid;
    logic [3:0]  dout_ready;
    logic        err_oor;
    // Second DUT: WIDTH=8, N=3 (exercises out-of-range select)
    logic        d3_rst_n;
    logic [7:0]  d3_din;
    logic [1:0]  d3_sel;
    logic        d3_din_valid;
    logic        d3_din_ready;
    logic [23:0] d3_dout;
    logic [2:0]  d3_dout_valid;
    logic [2:0]  d3_dout_ready;
    logic        d3_err_oor;
`ifdef DEMUX1TON_DROP_CNT_EN
    logic [15:0] drop_cnt;
    logic [15:0] d3_drop_cnt;
`endif

    int checks = 0;
    int errors = 0;

    demux1ton_stream #(.WIDTH(8), .N(4), .SELW(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .sel        (sel),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .err_oor    (err_oor)
`ifdef DEMUX1TON_DROP_CNT_EN
        ,
        .drop_cnt   (drop_cnt)
`endif
    );

    demux1ton_stream #(.WIDTH(8), .N(3), .SELW(2)) dut3 (
        .clk        (clk),
        .rst_n      (d3_rst_n),
        .din        (d3_din),
        .sel        (d3_sel),
        .din_valid  (d3_din_valid),
        .din_ready  (d3_din_ready),
        .dout       (d3_dout),
        .dout_valid (d3_dout_valid),
        .dout_ready (d3_dout_ready),
        .err_oor    (d3_err_oor)
`ifdef DEMUX1TON_DROP_CNT_EN
        ,
        .drop_cnt   (d3_drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       dv;
        logic [1:0] sel;
        logic [7:0] din;
        logic [3:0] rdy;
        logic       exp_drdy;
        logic [3:0] exp_dval;
        logic       chk_err;
    } vec_t;

    typedef struct packed {
        logic [1:0] ch;
        logic [7:0] data;
    } exp_t;

    vec_t vecs[25];
    exp_t sbq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Scoreboard sampling at the falling edge (inputs and outputs are stable
    // and equal to what the next rising edge will see), then advance.
    task automatic cycle();
        exp_t e;
        logic [3:0] oh;
        @(negedge clk);
        if (|(dout_valid & dout_ready)) begin
            if (sbq.size() == 0) begin
                chk("sb_unexpected_output", {28'd0, dout_valid}, 32'd0);
            end else begin
                e  = sbq.pop_front();
                oh = 4'b0001 << e.ch;
                chk($sformatf("sb_valid_ch%0d", e.ch), {28'd0, dout_valid}, {28'd0, oh});
                for (int k = 0; k < 4; k++) begin
                    chk($sformatf("sb_data_ch%0d_lane%0d", e.ch, k), {24'd0, dout[k*8 +: 8]}, {24'd0, e.data});
                end
                $display("xfer out ch%0d data=%02h", e.ch, dout[e.ch*8 +: 8]);
            end
        end
        if (!rst_n) begin
            sbq.delete();
        end else if (din_valid && din_ready) begin
            e.ch   = sel;
            e.data = din;
            sbq.push_back(e);
            $display("xfer in  ch%0d data=%02h", sel, din);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        //               rst  dv   sel   din    rdy      drdy dval     chk_err
        vecs[0]  = '{1'b0, 1'b1, 2'd0, 8'h33, 4'b1111, 1'b0, 4'b0000, 1'b0};
        vecs[1]  = '{1'b0, 1'b1, 2'd0, 8'h33, 4'b1111, 1'b0, 4'b0000, 1'b1};
        vecs[2]  = '{1'b1, 1'b1, 2'd2, 8'hA5, 4'b1111, 1'b1, 4'b0000, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0100, 1'b1};
        vecs[4]  = '{1'b1, 1'b1, 2'd0, 8'h10, 4'b1111, 1'b1, 4'b0000, 1'b1};
        vecs[5]  = '{1'b1, 1'b1, 2'd1, 8'h11, 4'b1111, 1'b1, 4'b0001, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 2'd2, 8'h12, 4'b1111, 1'b1, 4'b0010, 1'b1};
        vecs[7]  = '{1'b1, 1'b1, 2'd3, 8'h13, 4'b1111, 1'b1, 4'b0100, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b1000, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 2'd1, 8'h11, 4'b1101, 1'b1, 4'b0000, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 2'd3, 8'h22, 4'b1101, 1'b0, 4'b0010, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 2'd3, 8'h22, 4'b1101, 1'b0, 4'b0010, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 2'd3, 8'h22, 4'b1111, 1'b1, 4'b0010, 1'b1};
        vecs[14] = '{1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b1000, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 1'b1};
        vecs[16] = '{1'b1, 1'b1, 2'd3, 8'h44, 4'b0111, 1'b1, 4'b0000, 1'b1};
        vecs[17] = '{1'b1, 1'b1, 2'd0, 8'h55, 4'b0111, 1'b0, 4'b1000, 1'b1};
        vecs[18] = '{1'b1, 1'b1, 2'd0, 8'h55, 4'b1111, 1'b1, 4'b1000, 1'b1};
        vecs[19] = '{1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0001, 1'b1};
        vecs[20] = '{1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 1'b1};
        vecs[21] = '{1'b1, 1'b1, 2'd2, 8'h66, 4'b0000, 1'b1, 4'b0000, 1'b1};
        vecs[22] = '{1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 4'b0100, 1'b1};
        vecs[23] = '{1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b0, 4'b0000, 1'b1};
        vecs[24] = '{1'b1, 1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, 4'b0000, 1'b1};

        // Second DUT held in reset while the table runs.
        d3_rst_n      = 1'b0;
        d3_din        = 8'h00;
        d3_sel        = 2'd0;
        d3_din_valid  = 1'b0;
        d3_dout_ready = 3'b111;

        for (int i = 0; i < 25; i++) begin
            rst_n      = vecs[i].rst;
            din_valid  = vecs[i].dv;
            sel        = vecs[i].sel;
            din        = vecs[i].din;
            dout_ready = vecs[i].rdy;
            #1;
            chk($sformatf("row%0d_din_ready", i), {31'd0, din_ready}, {31'd0, vecs[i].exp_drdy});
            chk($sformatf("row%0d_dout_valid", i), {28'd0, dout_valid}, {28'd0, vecs[i].exp_dval});
            if (vecs[i].chk_err) begin
                chk($sformatf("row%0d_err_oor", i), {31'd0, err_oor}, 32'd0);
            end
            if (i == 24) begin
                chk("reset_clears_dout", dout, 32'd0);
            end
            cycle();
        end
        chk("sb_all_delivered", sbq.size(), 32'd0);

        // Out-of-range select on the N=3 instance.
        d3_rst_n     = 1'b1;
        d3_din_valid = 1'b1;
        d3_sel       = 2'd3;
        d3_din       = 8'hFF;
        #1;
        chk("oor_din_ready", {31'd0, d3_din_ready}, 32'd1);
        chk("oor_err_before", {31'd0, d3_err_oor}, 32'd0);
        cycle();
        d3_din_valid = 1'b0;
        #1;
        chk("oor_no_valid", {29'd0, d3_dout_valid}, 32'd0);
        chk("oor_err_set", {31'd0, d3_err_oor}, 32'd1);
`ifdef DEMUX1TON_DROP_CNT_EN
        chk("oor_drop_cnt1", {16'd0, d3_drop_cnt}, 32'd1);
`endif
        $display("n3 oor sel=3 din=ff err_oor=%0d", d3_err_oor);

        // In-range entry, then an out-of-range transfer while it drains.
        d3_din_valid = 1'b1;
        d3_sel       = 2'd1;
        d3_din       = 8'h5A;
        #1;
        chk("n3_load_ready", {31'd0, d3_din_ready}, 32'd1);
        cycle();
        d3_sel = 2'd3;
        d3_din = 8'h77;
        #1;
        chk("n3_valid_ch1", {29'd0, d3_dout_valid}, 32'b010);
        chk("n3_data_ch1", {24'd0, d3_dout[15:8]}, 32'h5A);
        chk("n3_drain_accept", {31'd0, d3_din_ready}, 32'd1);
        cycle();
        d3_din_valid = 1'b0;
        #1;
        chk("n3_drained_empty", {29'd0, d3_dout_valid}, 32'd0);
`ifdef DEMUX1TON_DROP_CNT_EN
        chk("oor_drop_cnt2", {16'd0, d3_drop_cnt}, 32'd2);
`endif
        for (int i = 0; i < 3; i++) cycle();
        chk("oor_err_sticky", {31'd0, d3_err_oor}, 32'd1);
        $display("n3 after idle err_oor=%0d", d3_err_oor);

        // Reset clears the sticky flag and holds din_ready low.
        d3_rst_n     = 1'b0;
        d3_din_valid = 1'b1;
        #1;
        chk("n3_rst_din_ready", {31'd0, d3_din_ready}, 32'd0);
        cycle();
        chk("n3_rst_err_clear", {31'd0, d3_err_oor}, 32'd0);
        chk("n3_rst_no_valid", {29'd0, d3_dout_valid}, 32'd0);
`ifdef DEMUX1TON_DROP_CNT_EN
        chk("n3_rst_drop_cnt", {16'd0, d3_drop_cnt}, 32'd0);
`endif
        d3_rst_n     = 1'b1;
        d3_din_valid = 1'b0;
        cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
